// File: rtl/dmem_periph_bridge.sv
// Data-memory bridge: decodes a 16-byte peripheral window (cycle timer with compare
// interrupt, byte TX FIFO) and passes every other access straight through to the RAM.
module dmem_periph_bridge #(
   parameter logic [31:0] PERIPH_BASE = 32'h8000_0000,
   parameter int unsigned FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwe,
   output logic [31:0] drdata,
   output logic [3:0]  mem_dwe,
   input  logic [31:0] mem_drdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        irq
);

   localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic           hit;
   logic [1:0]     off;
   logic           word_wr, st_wr, push_req, push_ok, pop, full, empty, match;
   logic [31:0]    reg_rdata;
   logic [3:0]     count4;
   logic           unused_addr_lsb;

   logic [31:0]    cnt_q, cnt_d;
   logic [31:0]    cmp_q, cmp_d;
   logic           pend_q, pend_d;
   logic           ovf_q, ovf_d;
   logic [PW-1:0]  rptr_q, rptr_d;
   logic [PW-1:0]  wptr_q, wptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [7:0]     mem_q [FIFO_DEPTH];

   assign hit             = (daddr[31:4] == PERIPH_BASE[31:4]);
   assign off             = daddr[3:2];
   assign unused_addr_lsb = ^daddr[1:0];

   assign word_wr  = (dwe == 4'b1111);
   assign st_wr    = hit & (off == 2'd1) & dwe[0] & ~reset;
   assign push_req = hit & (off == 2'd0) & dwe[0] & ~reset;

   assign full     = (count_q == DEPTH_C);
   assign empty    = (count_q == '0);
   assign tx_valid = ~empty;
   assign pop      = tx_valid & tx_ready;
   // A full FIFO still accepts a byte when the head leaves in the same cycle.
   assign push_ok  = push_req & (~full | pop);

   assign match    = (cnt_q == cmp_q);
   assign count4   = 4'(count_q);

   assign tx_data  = mem_q[rptr_q];
   assign irq      = pend_q;

   assign mem_dwe  = (hit | reset) ? 4'b0000 : dwe;
   assign drdata   = hit ? reg_rdata : mem_drdata;

   always_comb begin
      reg_rdata = '0;
      case (off)
         2'd0:    reg_rdata = '0;
         2'd1:    reg_rdata = {24'b0, count4, ovf_q, pend_q, empty, full};
         2'd2:    reg_rdata = cnt_q;
         default: reg_rdata = cmp_q;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q + 32'd1;
      if (hit && (off == 2'd2) && word_wr)
         cnt_d = dwdata;

      cmp_d = cmp_q;
      if (hit && (off == 2'd3) && word_wr)
         cmp_d = dwdata;

      // Sticky flags: a set in the same cycle as a software clear wins.
      pend_d = pend_q;
      if (st_wr && dwdata[2])
         pend_d = 1'b0;
      if (match)
         pend_d = 1'b1;

      ovf_d = ovf_q;
      if (st_wr && dwdata[3])
         ovf_d = 1'b0;
      if (push_req && !push_ok)
         ovf_d = 1'b1;

      rptr_d = pop     ? rptr_q + PW'(1) : rptr_q;
      wptr_d = push_ok ? wptr_q + PW'(1) : wptr_q;

      count_d = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         cmp_q   <= '1;
         pend_q  <= 1'b0;
         ovf_q   <= 1'b0;
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         cmp_q   <= cmp_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem_q[wptr_q] <= dwdata[7:0];
   end

endmodule

// File: tb/tb_dmem_periph_bridge.sv
// Scoreboard bench for dmem_periph_bridge: stimulus queues expected values per cycle and
// expected TX bytes; monitors compare on the falling edge.
module tb_dmem_periph_bridge;

   localparam logic [31:0] A_TX   = 32'h8000_0000;
   localparam logic [31:0] A_ST   = 32'h8000_0004;
   localparam logic [31:0] A_TIME = 32'h8000_0008;
   localparam logic [31:0] A_CMP  = 32'h8000_000C;

   localparam int S_RD   = 0;
   localparam int S_MWE  = 1;
   localparam int S_IRQ  = 2;
   localparam int S_TXV  = 3;
   localparam int S_TXD  = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] daddr, dwdata, mem_drdata;
   logic [3:0]  dwe;
   logic [31:0] drdata;
   logic [3:0]  mem_dwe;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready, irq;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int          q_cyc [$];
   int          q_sel [$];
   logic [31:0] q_exp [$];
   string       q_nm  [$];
   logic [7:0]  txq   [$];

   dmem_periph_bridge #(.PERIPH_BASE(32'h8000_0000), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
      .drdata(drdata), .mem_dwe(mem_dwe), .mem_drdata(mem_drdata),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .irq(irq)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] pick(input int sel);
      case (sel)
         S_RD:    return drdata;
         S_MWE:   return {28'b0, mem_dwe};
         S_IRQ:   return {31'b0, irq};
         S_TXV:   return {31'b0, tx_valid};
         default: return {24'b0, tx_data};
      endcase
   endfunction

   // Register/output monitor
   always @(negedge clk) begin
      logic [31:0] act;
      while (q_cyc.size() > 0 && q_cyc[0] <= cyc) begin
         act = pick(q_sel[0]);
         total = total + 1;
         if (q_cyc[0] != cyc || act !== q_exp[0]) begin
            bad = bad + 1;
            $display("FAIL %s cyc=%0d actual=%h required=%h", q_nm[0], q_cyc[0], act, q_exp[0]);
         end
         void'(q_cyc.pop_front());
         void'(q_sel.pop_front());
         void'(q_exp.pop_front());
         void'(q_nm.pop_front());
      end
   end

   // TX handshake monitor
   always @(negedge clk) begin
      logic [7:0] e;
      if (reset === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
         total = total + 1;
         if (txq.size() == 0) begin
            bad = bad + 1;
            $display("FAIL tx_unexpected cyc=%0d actual=%h required=none", cyc, tx_data);
         end else begin
            e = txq.pop_front();
            if (tx_data !== e) begin
               bad = bad + 1;
               $display("FAIL tx_byte cyc=%0d actual=%h required=%h", cyc, tx_data, e);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog");
   end

   task automatic exp_now(input string nm, input int sel, input logic [31:0] e);
      q_cyc.push_back(cyc);
      q_sel.push_back(sel);
      q_exp.push_back(e);
      q_nm.push_back(nm);
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
      daddr  = a;
      dwdata = d;
      dwe    = we;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      daddr = 32'h0000_0100;
      dwe   = 4'b0000;
   endtask

   task automatic do_reset();
      tx_ready = 1'b0;
      reset    = 1'b1;
      drive(32'h0000_0010, 32'h0BAD_F00D, 4'b1111);
      exp_now("rst_mem_dwe", S_MWE, 32'h0);
      step();
      reset = 1'b0;
      txq.delete();
   endtask

   task automatic push_byte(input logic [7:0] b, input bit accepted);
      drive(A_TX, {24'h0, b}, 4'b0001);
      if (accepted) txq.push_back(b);
   endtask

   initial begin
      logic [7:0] fill [5];
      logic [7:0] fill2 [4];
      fill  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      fill2 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
      reset = 1'b1; tx_ready = 1'b0; mem_drdata = 32'h0;
      drive(32'h0000_0100, 32'h0, 4'b0000);
      step();
      do_reset();

      // Reset state
      drive(A_TIME, 32'h0, 4'b0000);
      exp_now("rst_time", S_RD, 32'h0);
      exp_now("rst_irq", S_IRQ, 32'h0);
      exp_now("rst_txv", S_TXV, 32'h0);
      step();
      drive(A_ST, 32'h0, 4'b0000);
      exp_now("rst_status", S_RD, 32'h0000_0002);
      step();
      drive(A_CMP, 32'h0, 4'b0000);
      exp_now("rst_cmp", S_RD, 32'hFFFF_FFFF);
      step();

      // Pass-through and decode boundaries
      mem_drdata = 32'h1234_5678;
      drive(32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
      exp_now("pt_sw_dwe", S_MWE, 32'hF);
      exp_now("pt_sw_rd", S_RD, 32'h1234_5678);
      step();
      mem_drdata = 32'hCAFE_F00D;
      drive(32'h0000_0010, 32'h0, 4'b0000);
      exp_now("pt_lw", S_RD, 32'hCAFE_F00D);
      exp_now("pt_lw_dwe", S_MWE, 32'h0);
      step();
      drive(32'h8000_0010, 32'h0, 4'b1111);
      exp_now("edge_above_dwe", S_MWE, 32'hF);
      exp_now("edge_above_rd", S_RD, 32'hCAFE_F00D);
      step();
      drive(32'h0000_0024, 32'h0, 4'b0101);
      exp_now("pt_partial_dwe", S_MWE, 32'h5);
      step();
      mem_drdata = 32'hFFFF_FFFF;
      drive(A_TX, 32'h0, 4'b0000);
      exp_now("txdata_rd0", S_RD, 32'h0);
      step();
      drive(A_TIME, 32'hDEAD_BEEF, 4'b1111);
      exp_now("hit_sw_dwe", S_MWE, 32'h0);
      step();
      drive(A_TIME, 32'h0, 4'b0011);
      exp_now("time_loaded", S_RD, 32'hDEAD_BEEF);
      step();
      drive(A_TIME, 32'h0, 4'b0000);
      exp_now("time_partial_ign", S_RD, 32'hDEAD_BEF0);
      step();

      // Timer count and wrap
      do_reset();
      for (int i = 0; i <= 10; i++) begin
         drive(A_TIME, 32'h0, 4'b0000);
         exp_now("time_count", S_RD, 32'(i));
         step();
      end
      drive(A_TIME, 32'hFFFF_FFFE, 4'b1111);
      step();
      drive(A_TIME, 32'h0, 4'b0000); exp_now("wrap0", S_RD, 32'hFFFF_FFFE); step();
      drive(A_TIME, 32'h0, 4'b0000); exp_now("wrap1", S_RD, 32'hFFFF_FFFF); step();
      drive(A_TIME, 32'h0, 4'b0000); exp_now("wrap2", S_RD, 32'h0);         step();

      // Compare / irq: counter equals cycle index after reset
      do_reset();
      drive(A_CMP, 32'd20, 4'b1111);
      exp_now("irq_c0", S_IRQ, 32'h0);
      step();
      for (int k = 1; k <= 24; k++) begin
         exp_now("irq_rise", S_IRQ, (k >= 21) ? 32'h1 : 32'h0);
         if (k == 21) begin
            drive(A_ST, 32'h0, 4'b0000);
            exp_now("status_pend", S_RD, 32'h0000_0006);
         end
         step();
      end
      drive(A_ST, 32'h4, 4'b0001);
      exp_now("irq_before_clr", S_IRQ, 32'h1);
      step();
      exp_now("irq_cleared", S_IRQ, 32'h0);
      drive(A_CMP, 32'd30, 4'b1111);
      step();
      for (int k = 27; k <= 29; k++) begin
         exp_now("irq_low", S_IRQ, 32'h0);
         step();
      end
      drive(A_ST, 32'h4, 4'b0001);
      exp_now("irq_match_cyc", S_IRQ, 32'h0);
      step();
      exp_now("irq_set_wins", S_IRQ, 32'h1);
      drive(A_ST, 32'h4, 4'b0001);
      step();
      exp_now("irq_clr2", S_IRQ, 32'h0);
      step();

      // FIFO fill and overflow
      do_reset();
      for (int i = 0; i < 5; i++) begin
         push_byte(fill[i], i < 4);
         step();
      end
      drive(A_ST, 32'h0, 4'b0000);
      exp_now("status_full_ovf", S_RD, 32'h0000_0049);
      exp_now("full_txv", S_TXV, 32'h1);
      exp_now("held_txd", S_TXD, 32'h11);
      step();
      tx_ready = 1'b1;
      repeat (4) step();
      exp_now("drained_txv", S_TXV, 32'h0);
      drive(A_ST, 32'h8, 4'b0001);
      step();
      drive(A_ST, 32'h0, 4'b0000);
      exp_now("ovf_cleared", S_RD, 32'h0000_0002);
      step();

      // Full FIFO with simultaneous push and pop
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         push_byte(fill2[i], 1'b1);
         step();
      end
      tx_ready = 1'b1;
      push_byte(8'h66, 1'b1);
      step();
      tx_ready = 1'b0;
      drive(A_ST, 32'h0, 4'b0000);
      exp_now("pushpop_status", S_RD, 32'h0000_0041);
      step();
      tx_ready = 1'b1;
      repeat (4) step();
      exp_now("pushpop_empty", S_TXV, 32'h0);
      tx_ready = 1'b0;
      step();

      // Reset mid-stream
      drive(A_CMP, 32'h55, 4'b1111);
      step();
      for (int i = 0; i < 3; i++) begin
         push_byte(8'hB1 + 8'(i), 1'b1);
         step();
      end
      do_reset();
      tx_ready = 1'b1;
      drive(A_TIME, 32'h0, 4'b0000);
      exp_now("mid_rst_time", S_RD, 32'h0);
      exp_now("mid_rst_txv", S_TXV, 32'h0);
      step();
      drive(A_ST, 32'h0, 4'b0000);
      exp_now("mid_rst_status", S_RD, 32'h0000_0002);
      step();
      drive(A_CMP, 32'h0, 4'b0000);
      exp_now("mid_rst_cmp", S_RD, 32'hFFFF_FFFF);
      step();
      tx_ready = 1'b0;
      push_byte(8'hC7, 1'b1);
      step();
      tx_ready = 1'b1;
      step();
      exp_now("post_rst_empty", S_TXV, 32'h0);
      step();
      step();

      total = total + 1;
      if (txq.size() != 0) begin
         bad = bad + 1;
         $display("FAIL tx_leftover actual=%0d required=0", txq.size());
      end
      total = total + 1;
      if (q_cyc.size() != 0) begin
         bad = bad + 1;
         $display("FAIL chk_leftover actual=%0d required=0", q_cyc.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
